// File: rtl/ppi_gen.sv
// ppi_gen: multi-port programmable peripheral interface with basic,
// strobed-in and strobed-out modes, per-port FIFO and handshake pins.
module ppi_gen #(
    parameter int NPORTS = 2,
    parameter int DW = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(NPORTS) + 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [AW-1:0]        addr,
    input  logic [DW-1:0]        wdata,
    output logic [DW-1:0]        rdata,
    input  logic [NPORTS*DW-1:0] pin_in,
    output logic [NPORTS*DW-1:0] pin_out,
    output logic [NPORTS*DW-1:0] pin_oe,
    input  logic [NPORTS-1:0]    stb_n,
    input  logic [NPORTS-1:0]    ack_n,
    output logic [NPORTS-1:0]    ibf,
    output logic [NPORTS-1:0]    obf_n,
    output logic [NPORTS-1:0]    intr
);

    localparam int PTW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    localparam logic [1:0] M_BASIC = 2'b00;
    localparam logic [1:0] M_SIN = 2'b10;
    localparam logic [1:0] M_SOUT = 2'b11;

    typedef enum logic [1:0] {
        O_IDLE = 2'd0,
        O_PRESENT = 2'd1,
        O_HOLD = 2'd2
    } ost_t;

    function automatic logic [1:0] eff_mode(input logic [1:0] m);
        return (m == 2'b01) ? M_BASIC : m;
    endfunction

    logic [NPORTS*DW-1:0] pin_s1, pin_s2;
    logic [NPORTS-1:0] stb_s1, stb_s2, stb_s3;
    logic [NPORTS-1:0] ack_s1, ack_s2, ack_s3;
    logic [NPORTS-1:0] stb_fall, ack_fall, ack_rise;

    logic [1:0]     mode   [NPORTS];
    logic           ien    [NPORTS];
    logic [DW-1:0]  dir    [NPORTS];
    logic [DW-1:0]  outreg [NPORTS];
    logic [DW-1:0]  oreg   [NPORTS];
    logic           ovf    [NPORTS];
    logic [DW-1:0]  mem    [NPORTS][DEPTH];
    logic [PTW-1:0] wp     [NPORTS];
    logic [PTW-1:0] rp     [NPORTS];
    logic [LW-1:0]  lvl    [NPORTS];
    ost_t           ost    [NPORTS];

    logic [31:0]   aport;
    logic          sel    [NPORTS];
    logic          empty  [NPORTS];
    logic          full   [NPORTS];
    logic          mchg   [NPORTS];
    logic          push   [NPORTS];
    logic          pop    [NPORTS];
    logic          pok    [NPORTS];
    logic          intr_c [NPORTS];
    logic [DW-1:0] head   [NPORTS];
    logic [DW-1:0] pdata  [NPORTS];
    logic [7:0]    stat   [NPORTS];
    logic [DW-1:0] rd_val;

    assign stb_fall = stb_s3 & ~stb_s2;
    assign ack_fall = ack_s3 & ~ack_s2;
    assign ack_rise = ~ack_s3 & ack_s2;

    always_comb begin
        aport = 32'(addr >> 2);
        for (int p = 0; p < NPORTS; p++) begin
            sel[p] = (aport == 32'(p));
            empty[p] = (lvl[p] == '0);
            full[p] = (lvl[p] == LW'(DEPTH));
            head[p] = mem[p][rp[p]];
            mchg[p] = wr_en && sel[p] && (addr[1:0] == 2'd1)
                      && (eff_mode(wdata[1:0]) != mode[p]);
            push[p] = 1'b0;
            pop[p] = 1'b0;
            pdata[p] = wdata;
            intr_c[p] = 1'b0;
            case (mode[p])
                M_SIN: begin
                    push[p] = stb_fall[p];
                    pop[p] = rd_en && !wr_en && sel[p]
                             && (addr[1:0] == 2'd0) && !empty[p];
                    pdata[p] = pin_s2[p*DW +: DW];
                    intr_c[p] = ien[p] && !empty[p];
                end
                M_SOUT: begin
                    push[p] = wr_en && sel[p] && (addr[1:0] == 2'd0);
                    pop[p] = (ost[p] == O_PRESENT) && ack_fall[p];
                    intr_c[p] = ien[p] && empty[p] && (ost[p] == O_IDLE);
                end
                default: ;
            endcase
            pok[p] = push[p] && (!full[p] || pop[p]);
        end
    end

    always_comb begin
        pin_out = '0;
        pin_oe = '0;
        ibf = '0;
        obf_n = '1;
        intr = '0;
        rd_val = '0;
        for (int p = 0; p < NPORTS; p++) begin
            // Only strobed-out drives from the presented FIFO word
            pin_out[p*DW +: DW] = (mode[p] == M_SOUT) ? oreg[p] : outreg[p];
            pin_oe[p*DW +: DW] = (mode[p] == M_BASIC) ? dir[p]
                               : (mode[p] == M_SOUT) ? '1 : '0;
            ibf[p] = (mode[p] == M_SIN) && !empty[p];
            obf_n[p] = !((mode[p] == M_SOUT) && (ost[p] == O_PRESENT));
            intr[p] = intr_c[p];
            stat[p] = {(32'(lvl[p]) > 32'd15) ? 4'hF : 4'(lvl[p]),
                       intr_c[p], ovf[p], full[p], empty[p]};
            if (sel[p]) begin
                case (addr[1:0])
                    2'd0: begin
                        if (mode[p] == M_BASIC)
                            rd_val = (dir[p] & outreg[p])
                                   | (~dir[p] & pin_s2[p*DW +: DW]);
                        else if (mode[p] == M_SIN && !empty[p])
                            rd_val = head[p];
                    end
                    2'd1: rd_val = DW'({ien[p], mode[p]});
                    2'd2: rd_val = DW'(stat[p]);
                    default: rd_val = dir[p];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pin_s1 <= '0;
            pin_s2 <= '0;
            stb_s1 <= '1;
            stb_s2 <= '1;
            stb_s3 <= '1;
            ack_s1 <= '1;
            ack_s2 <= '1;
            ack_s3 <= '1;
            rdata <= '0;
            for (int p = 0; p < NPORTS; p++) begin
                mode[p] <= M_BASIC;
                ien[p] <= 1'b0;
                dir[p] <= '0;
                outreg[p] <= '0;
                oreg[p] <= '0;
                ovf[p] <= 1'b0;
                wp[p] <= '0;
                rp[p] <= '0;
                lvl[p] <= '0;
                ost[p] <= O_IDLE;
                for (int d = 0; d < DEPTH; d++)
                    mem[p][d] <= '0;
            end
        end else begin
            pin_s1 <= pin_in;
            pin_s2 <= pin_s1;
            stb_s1 <= stb_n;
            stb_s2 <= stb_s1;
            stb_s3 <= stb_s2;
            ack_s1 <= ack_n;
            ack_s2 <= ack_s1;
            ack_s3 <= ack_s2;
            if (rd_en)
                rdata <= wr_en ? '0 : rd_val;
            for (int p = 0; p < NPORTS; p++) begin
                if (wr_en && sel[p]) begin
                    case (addr[1:0])
                        2'd0: if (mode[p] == M_BASIC) outreg[p] <= wdata;
                        2'd1: begin
                            mode[p] <= eff_mode(wdata[1:0]);
                            ien[p] <= wdata[2];
                        end
                        2'd2: if (wdata[2]) ovf[p] <= 1'b0;
                        default: dir[p] <= wdata;
                    endcase
                end
                if (mchg[p]) begin
                    wp[p] <= '0;
                    rp[p] <= '0;
                    lvl[p] <= '0;
                    ovf[p] <= 1'b0;
                    ost[p] <= O_IDLE;
                end else begin
                    if (pok[p]) begin
                        mem[p][wp[p]] <= pdata[p];
                        wp[p] <= wp[p] + PTW'(1);
                    end else if (push[p]) begin
                        ovf[p] <= 1'b1;
                    end
                    if (pop[p])
                        rp[p] <= rp[p] + PTW'(1);
                    lvl[p] <= lvl[p] + LW'(pok[p]) - LW'(pop[p]);
                    case (ost[p])
                        O_IDLE: begin
                            if (mode[p] == M_SOUT && !empty[p]) begin
                                oreg[p] <= head[p];
                                ost[p] <= O_PRESENT;
                            end
                        end
                        O_PRESENT: if (ack_fall[p]) ost[p] <= O_HOLD;
                        O_HOLD: if (ack_rise[p]) ost[p] <= O_IDLE;
                        default: ost[p] <= O_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ppi_gen.sv
// tb_ppi_gen: directed checks of ppi_gen with three 8-bit ports,
// covering basic, strobed-in, strobed-out, overflow, mode change and reset.
module tb_ppi_gen;

    localparam int NP = 3;
    localparam int DW = 8;
    localparam int DEPTH = 4;
    localparam int AW = 4;

    logic           clk;
    logic           reset;
    logic           wr_en;
    logic           rd_en;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic [DW-1:0]  rdata;
    logic [NP*DW-1:0] pin_in;
    logic [NP*DW-1:0] pin_out;
    logic [NP*DW-1:0] pin_oe;
    logic [NP-1:0]  stb_n;
    logic [NP-1:0]  ack_n;
    logic [NP-1:0]  ibf;
    logic [NP-1:0]  obf_n;
    logic [NP-1:0]  intr;

    int checks = 0;
    int passed = 0;
    int fails = 0;
    logic [7:0] d;
    logic [7:0] exp_q [4];

    ppi_gen #(.NPORTS(NP), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .addr(addr),
        .wdata(wdata),
        .rdata(rdata),
        .pin_in(pin_in),
        .pin_out(pin_out),
        .pin_oe(pin_oe),
        .stb_n(stb_n),
        .ack_n(ack_n),
        .ibf(ibf),
        .obf_n(obf_n),
        .intr(intr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] v);
        addr = a;
        wdata = v;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] v);
        addr = a;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        v = rdata;
    endtask

    task automatic strobe(input int p, input logic [7:0] v);
        pin_in[p*8 +: 8] = v;
        repeat (3) tick();
        stb_n[p] = 1'b0;
        repeat (3) tick();
        stb_n[p] = 1'b1;
        repeat (3) tick();
    endtask

    task automatic ack(input int p);
        ack_n[p] = 1'b0;
        repeat (3) tick();
        ack_n[p] = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        addr = '0;
        wdata = '0;
        pin_in = '0;
        stb_n = '1;
        ack_n = '1;
        #12;
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_oe", 32'(pin_oe), 32'h0);
        check("rst_out", 32'(pin_out), 32'h0);
        check("rst_hs", 32'({ibf, obf_n, intr}), 32'h038);
        reset = 1'b0;
        tick();
        rd(4'h1, d);
        check("rst_ctrl", 32'(d), 32'h00);

        // basic mode on port 0
        wr(4'h3, 8'hF0);
        wr(4'h0, 8'hA5);
        pin_in[7:0] = 8'h3C;
        repeat (2) tick();
        check("t1_oe", 32'(pin_oe), 32'h0000F0);
        check("t1_out", 32'(pin_out[7:0]), 32'hA5);
        rd(4'h0, d);
        check("t1_read", 32'(d), 32'hAC);

        // strobed in with interrupt
        wr(4'h1, 8'h06);
        check("t2_oe", 32'(pin_oe[7:0]), 32'h00);
        strobe(0, 8'h11);
        strobe(0, 8'h22);
        strobe(0, 8'h33);
        check("t2_ibf", 32'(ibf[0]), 32'h1);
        check("t2_intr", 32'(intr[0]), 32'h1);
        rd(4'h2, d);
        check("t2_stat", 32'(d), 32'h38);
        rd(4'h0, d);
        check("t2_pop0", 32'(d), 32'h11);
        rd(4'h0, d);
        check("t2_pop1", 32'(d), 32'h22);
        rd(4'h0, d);
        check("t2_pop2", 32'(d), 32'h33);
        check("t2_ibf0", 32'(ibf[0]), 32'h0);
        check("t2_intr0", 32'(intr[0]), 32'h0);
        rd(4'h0, d);
        check("t2_empty_rd", 32'(d), 32'h00);

        // overflow and simultaneous push/pop when full
        strobe(0, 8'h01);
        strobe(0, 8'h02);
        strobe(0, 8'h03);
        strobe(0, 8'h04);
        strobe(0, 8'h05);
        rd(4'h2, d);
        check("t3_ovf_stat", 32'(d), 32'h4E);
        wr(4'h2, 8'h04);
        rd(4'h2, d);
        check("t3_ovf_clr", 32'(d), 32'h4A);
        pin_in[7:0] = 8'h06;
        repeat (3) tick();
        stb_n[0] = 1'b0;
        repeat (2) tick();
        addr = 4'h0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("t3_edge_rd", 32'(rdata), 32'h01);
        stb_n[0] = 1'b1;
        repeat (3) tick();
        rd(4'h2, d);
        check("t3_edge_lvl", 32'(d), 32'h4A);
        exp_q[0] = 8'h02;
        exp_q[1] = 8'h03;
        exp_q[2] = 8'h04;
        exp_q[3] = 8'h06;
        for (int i = 0; i < 4; i++) begin
            rd(4'h0, d);
            check($sformatf("t3_drain%0d", i), 32'(d), 32'(exp_q[i]));
        end
        rd(4'h2, d);
        check("t3_empty", 32'(d), 32'h01);

        // strobed out on port 1
        wr(4'h5, 8'h07);
        check("t4_oe", 32'(pin_oe[15:8]), 32'hFF);
        check("t4_drained", 32'(intr[1]), 32'h1);
        wr(4'h4, 8'h5A);
        wr(4'h4, 8'h6B);
        tick();
        check("t4_obf0", 32'(obf_n[1]), 32'h0);
        check("t4_out0", 32'(pin_out[15:8]), 32'h5A);
        check("t4_intr0", 32'(intr[1]), 32'h0);
        ack(1);
        check("t4_obf_ack", 32'(obf_n[1]), 32'h1);
        check("t4_hold", 32'(pin_out[15:8]), 32'h5A);
        repeat (4) tick();
        check("t4_obf1", 32'(obf_n[1]), 32'h0);
        check("t4_out1", 32'(pin_out[15:8]), 32'h6B);
        ack(1);
        repeat (3) tick();
        check("t4_intr1", 32'(intr[1]), 32'h1);
        check("t4_obf_end", 32'(obf_n[1]), 32'h1);
        check("t4_out_end", 32'(pin_out[15:8]), 32'h6B);

        // mode change flush, then reset while presenting
        wr(4'h4, 8'hC1);
        wr(4'h4, 8'hC2);
        tick();
        check("t5_obf", 32'(obf_n[1]), 32'h0);
        rd(4'h6, d);
        check("t5_lvl2", 32'(d), 32'h20);
        wr(4'h4, 8'hC3);
        wr(4'h4, 8'hC4);
        wr(4'h4, 8'hC5);
        rd(4'h6, d);
        check("t5_full", 32'(d), 32'h46);
        wr(4'h5, 8'h02);
        rd(4'h6, d);
        check("t5_flush", 32'(d), 32'h01);
        check("t5_obf_idle", 32'(obf_n[1]), 32'h1);
        wr(4'h5, 8'h07);
        wr(4'h4, 8'h77);
        tick();
        check("t5_pre_obf", 32'(obf_n[1]), 32'h0);
        check("t5_pre_out", 32'(pin_out[15:8]), 32'h77);
        reset = 1'b1;
        #1;
        check("t5_rdata", 32'(rdata), 32'h0);
        check("t5_oe", 32'(pin_oe), 32'h0);
        check("t5_out", 32'(pin_out), 32'h0);
        check("t5_hs", 32'({ibf, obf_n, intr}), 32'h038);
        #3;
        reset = 1'b0;
        tick();

        // port 2 independence and out-of-range port
        wr(4'hB, 8'hFF);
        wr(4'h8, 8'h3E);
        check("t6_oe", 32'(pin_oe), 32'hFF0000);
        check("t6_out", 32'(pin_out), 32'h3E0000);
        rd(4'h8, d);
        check("t6_read", 32'(d), 32'h3E);
        wr(4'hC, 8'h55);
        wr(4'hF, 8'hFF);
        check("t6_oor_oe", 32'(pin_oe), 32'hFF0000);
        check("t6_oor_out", 32'(pin_out), 32'h3E0000);
        rd(4'hF, d);
        check("t6_oor_rd", 32'(d), 32'h00);
        wr(4'h1, 8'h06);
        strobe(0, 8'h9C);
        check("t6_ibf", 32'(ibf), 32'h1);
        check("t6_p2_keep", 32'(pin_out[23:16]), 32'h3E);
        rd(4'h0, d);
        check("t6_p0_rd", 32'(d), 32'h9C);
        addr = 4'h8;
        wdata = 8'hC3;
        wr_en = 1'b1;
        rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("t6_wrrd_rdata", 32'(rdata), 32'h00);
        check("t6_wrrd_out", 32'(pin_out[23:16]), 32'hC3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
